// File: rtl/vga_scene_renderer.sv
// 640x480@60 VGA timing plus a per-frame snapshot of game state, rendered as
// dinosaur box, ground line and scrolling ground texture in 12-bit RGB.
module vga_scene_renderer #(
  parameter int CLK_DIV      = 4,
  parameter int H_VISIBLE    = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int GROUND_Y     = 400,
  parameter int DINO_X       = 64,
  parameter int DINO_W       = 32,
  parameter int DINO_H       = 40,
  parameter int HEIGHT_SCALE = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] dinosaur_height,
  input  logic [5:0] ground_position,
  input  logic       game_status,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] GND_Y    = 10'(GROUND_Y);
  localparam logic [9:0] TEX_END  = 10'(GROUND_Y + 3);
  localparam logic [9:0] D_LEFT   = 10'(DINO_X);
  localparam logic [9:0] D_RIGHT  = 10'(DINO_X + DINO_W);
  localparam logic [9:0] D_HEIGHT = 10'(DINO_H);
  localparam logic [9:0] H_SCALE  = 10'(HEIGHT_SCALE);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [5:0]  height_q, height_d, gpos_q, gpos_d;
  logic        status_q, status_d;
  logic        hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [11:0] rgb_q, rgb_d;

  logic        pix_en, snap_en, visible, in_dino;
  logic [9:0]  dino_bot, dino_top;
  logic [3:0]  tex_sum;
  logic [11:0] colour;

  always_comb begin
    pix_en  = (div_q == DIV_LAST);
    div_d   = pix_en ? '0 : div_q + DIV_W'(1);

    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    // Latch game state at the start of vertical blanking so a frame never tears.
    snap_en  = pix_en && (h_q == '0) && (v_q == V_VIS);
    fs_d     = snap_en;
    height_d = snap_en ? dinosaur_height : height_q;
    gpos_d   = snap_en ? ground_position : gpos_q;
    status_d = snap_en ? game_status     : status_q;

    dino_bot = GND_Y - 10'(height_q) * H_SCALE;
    dino_top = dino_bot - D_HEIGHT;
    tex_sum  = h_q[3:0] + gpos_q[3:0];
    visible  = (h_q < H_VIS) && (v_q < V_VIS);
    in_dino  = (h_q >= D_LEFT) && (h_q < D_RIGHT) &&
               (v_q >= dino_top) && (v_q < dino_bot);

    if (!visible)
      colour = 12'h000;
    else if (in_dino)
      colour = status_q ? 12'hF00 : 12'h555;
    else if (v_q == GND_Y)
      colour = 12'h333;
    else if ((v_q > GND_Y) && (v_q <= TEX_END) && !tex_sum[3])
      colour = 12'h888;
    else
      colour = 12'hFFF;

    hs_d  = hs_q;
    vs_d  = vs_q;
    rgb_d = rgb_q;
    if (pix_en) begin
      hs_d  = !((h_q >= HS_START) && (h_q < HS_END));
      vs_d  = !((v_q >= VS_START) && (v_q < VS_END));
      rgb_d = colour;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      height_q <= '0;
      gpos_q   <= '0;
      status_q <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      rgb_q    <= '0;
      fs_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      height_q <= height_d;
      gpos_q   <= gpos_d;
      status_q <= status_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      rgb_q    <= rgb_d;
      fs_q     <= fs_d;
    end
  end

  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_R       = rgb_q[11:8];
  assign VGA_G       = rgb_q[7:4];
  assign VGA_B       = rgb_q[3:0];
  assign frame_start = fs_q;

endmodule
